// File: rtl/lsu.sv
// Load/store unit: one outstanding memory access with a wait-timeout.
// Ports: clk/rst, ex_* request, stall, mem_* bus, wb_* load result, exc_* pulses.
module lsu #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_read,
  input  logic        ex_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_misalign,
  output logic        exc_timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] LIM  = 8'(MAX_WAIT - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        wbv_q, wbv_d;
  logic [31:0] wbd_q, wbd_d;
  logic        mis_q, mis_d;
  logic        tmo_q, tmo_d;

  logic        is_st;
  logic        f3_ok;
  logic        misal;
  logic        req;
  logic        go;
  logic        bad_al;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] rsh;
  logic [15:0] hw;
  logic [31:0] ld_data;

  // Both read and write set: the load wins.
  assign is_st = ex_write & ~ex_read;

  always_comb begin
    f3_ok = 1'b0;
    misal = 1'b0;
    unique case (ex_funct3)
      3'b000: f3_ok = 1'b1;
      3'b001: begin
        f3_ok = 1'b1;
        misal = ex_addr[0];
      end
      3'b010: begin
        f3_ok = 1'b1;
        misal = |ex_addr[1:0];
      end
      3'b100: f3_ok = ~is_st;
      3'b101: begin
        f3_ok = ~is_st;
        misal = ex_addr[0];
      end
      default: f3_ok = 1'b0;
    endcase
  end

  assign req    = ex_valid & (ex_read | ex_write)
                & (state_q == IDLE);
  assign go     = req & f3_ok & ~misal;
  assign bad_al = req & f3_ok & misal;

  assign stall = ~rst & ((state_q == BUSY) | go);

  always_comb begin
    st_wdata = 32'h0;
    st_be    = 4'b1111;
    if (is_st) begin
      unique case (ex_funct3)
        3'b000: begin
          st_wdata = {4{ex_wdata[7:0]}};
          st_be    = 4'b0001 << ex_addr[1:0];
        end
        3'b001: begin
          st_wdata = {2{ex_wdata[15:0]}};
          st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: st_wdata = ex_wdata;
      endcase
    end
  end

  // Lane select from the latched byte offset.
  assign rsh = mem_rdata >> {off_q, 3'b000};
  assign hw  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    unique case (f3_q)
      3'b000:  ld_data = {{24{rsh[7]}}, rsh[7:0]};
      3'b001:  ld_data = {{16{hw[15]}}, hw};
      3'b100:  ld_data = {24'h0, rsh[7:0]};
      3'b101:  ld_data = {16'h0, hw};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    off_d   = off_q;
    wbv_d   = 1'b0;
    wbd_d   = wbd_q;
    mis_d   = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        mis_d = bad_al;
        if (go) begin
          state_d = BUSY;
          cnt_d   = 8'h0;
          req_d   = 1'b1;
          we_d    = is_st;
          addr_d  = {ex_addr[31:2], 2'b00};
          wdata_d = st_wdata;
          be_d    = st_be;
          rd_d    = ex_rd;
          f3_d    = ex_funct3;
          off_d   = ex_addr[1:0];
        end
      end
      BUSY: begin
        // Ack beats the timeout on the final wait cycle.
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wbv_d   = ~we_q;
          if (!we_q) wbd_d = ld_data;
        end else if (cnt_q == LIM) begin
          state_d = IDLE;
          req_d   = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'h0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rd_q    <= 5'h0;
      f3_q    <= 3'h0;
      off_q   <= 2'h0;
      wbv_q   <= 1'b0;
      wbd_q   <= 32'h0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      wbv_q   <= wbv_d;
      wbd_q   <= wbd_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_be       = be_q;
  assign wb_valid     = wbv_q;
  assign wb_rd        = rd_q;
  assign wb_data      = wbd_q;
  assign exc_misalign = mis_q;
  assign exc_timeout  = tmo_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with MAX_WAIT=4.
// Hand-computed vectors; one summary line at the end.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_read = 1'b0;
  logic        ex_write = 1'b0;
  logic [2:0]  ex_funct3 = 3'b0;
  logic [31:0] ex_addr = 32'h0;
  logic [31:0] ex_wdata = 32'h0;
  logic [4:0]  ex_rd = 5'h0;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_misalign;
  logic        exc_timeout;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_read(ex_read),
    .ex_write(ex_write), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rd(ex_rd), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_misalign(exc_misalign),
    .exc_timeout(exc_timeout)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; check stall mid-cycle.
  task automatic issue(bit r, bit w, logic [2:0] f3,
                       logic [31:0] a, logic [31:0] wd,
                       logic [4:0] d, bit exp_st,
                       string tag);
    ex_valid  = 1'b1;
    ex_read   = r;
    ex_write  = w;
    ex_funct3 = f3;
    ex_addr   = a;
    ex_wdata  = wd;
    ex_rd     = d;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall), 32'(exp_st));
    cyc();
    ex_valid = 1'b0;
    ex_read  = 1'b0;
    ex_write = 1'b0;
  endtask

  task automatic ack_now(logic [31:0] d);
    mem_ack   = 1'b1;
    mem_rdata = d;
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic chk_load(string tag, logic [2:0] f3,
                          logic [31:0] a, logic [31:0] rd,
                          logic [31:0] exp);
    issue(1, 0, f3, a, 32'h0, 5'd3, 1, tag);
    chk({tag, ".req"}, 32'(mem_req), 32'd1);
    chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
    ack_now(rd);
    chk({tag, ".wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, ".data"}, wb_data, exp);
  endtask

  initial begin
    // Reset with a live request: stall must stay low.
    ex_valid  = 1'b1;
    ex_read   = 1'b1;
    ex_funct3 = 3'b010;
    ex_addr   = 32'h100;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.addr", mem_addr, 32'h0);
    chk("rst.be", 32'(mem_be), 32'h0);
    chk("rst.wbv", 32'(wb_valid), 32'd0);
    chk("rst.wbd", wb_data, 32'h0);
    chk("rst.exc", {exc_misalign, exc_timeout}, 32'd0);
    ex_valid = 1'b0;
    ex_read  = 1'b0;
    rst      = 1'b0;
    cyc();

    // LB, minimum latency.
    issue(1, 0, 3'b000, 32'h1003, 32'h0, 5'd7, 1, "lb");
    chk("lb.req", 32'(mem_req), 32'd1);
    chk("lb.we", 32'(mem_we), 32'd0);
    chk("lb.addr", mem_addr, 32'h1000);
    chk("lb.be", 32'(mem_be), 32'hF);
    chk("lb.rd", 32'(wb_rd), 32'd7);
    chk("lb.stallb", 32'(stall), 32'd1);
    ack_now(32'h80FF_FF00);
    chk("lb.wbv", 32'(wb_valid), 32'd1);
    chk("lb.data", wb_data, 32'hFFFF_FF80);
    chk("lb.reqlo", 32'(mem_req), 32'd0);
    chk("lb.stlo", 32'(stall), 32'd0);

    // Back-to-back: accepted in first IDLE cycle.
    chk_load("lhu", 3'b101, 32'h1002,
             32'h8001_0000, 32'h0000_8001);
    chk_load("lh", 3'b001, 32'h1002,
             32'h8001_0000, 32'hFFFF_8001);
    chk_load("lbu", 3'b100, 32'h1001,
             32'h0000_9A00, 32'h0000_009A);
    chk_load("lw", 3'b010, 32'h1004,
             32'hDEAD_BEEF, 32'hDEAD_BEEF);
    cyc();
    chk("lw.wbv1", 32'(wb_valid), 32'd0);

    // SB and SH.
    issue(0, 1, 3'b000, 32'h2001, 32'h1234_56AB,
          5'd0, 1, "sb");
    chk("sb.we", 32'(mem_we), 32'd1);
    chk("sb.be", 32'(mem_be), 32'b0010);
    chk("sb.wd", mem_wdata, 32'hABAB_ABAB);
    chk("sb.addr", mem_addr, 32'h2000);
    ack_now(32'h0);
    chk("sb.wbv", 32'(wb_valid), 32'd0);
    issue(0, 1, 3'b001, 32'h2002, 32'h1234_56AB,
          5'd0, 1, "sh");
    chk("sh.be", 32'(mem_be), 32'b1100);
    chk("sh.wd", mem_wdata, 32'h56AB_56AB);
    ack_now(32'h0);
    chk("sh.wbv", 32'(wb_valid), 32'd0);

    // Read+write together acts as a load.
    issue(1, 1, 3'b010, 32'h2008, 32'h5555_5555,
          5'd4, 1, "rw");
    chk("rw.we", 32'(mem_we), 32'd0);
    ack_now(32'h0BAD_F00D);
    chk("rw.wbv", 32'(wb_valid), 32'd1);
    chk("rw.data", wb_data, 32'h0BAD_F00D);

    // Misaligned LW.
    issue(1, 0, 3'b010, 32'h3002, 32'h0, 5'd1, 0, "mis");
    chk("mis.req", 32'(mem_req), 32'd0);
    chk("mis.exc", 32'(exc_misalign), 32'd1);
    cyc();
    chk("mis.exc1", 32'(exc_misalign), 32'd0);

    // Invalid funct3: SBU-style store, and 011.
    issue(0, 1, 3'b100, 32'h3000, 32'h0, 5'd1, 0, "inv1");
    chk("inv1.req", 32'(mem_req), 32'd0);
    chk("inv1.exc", 32'(exc_misalign), 32'd0);
    issue(1, 0, 3'b011, 32'h3001, 32'h0, 5'd1, 0, "inv2");
    chk("inv2.req", 32'(mem_req), 32'd0);
    chk("inv2.exc", 32'(exc_misalign), 32'd0);

    // Ack in IDLE ignored.
    ack_now(32'h1111_1111);
    chk("idack.wbv", 32'(wb_valid), 32'd0);

    // Timeout: 4 BUSY cycles then pulse.
    issue(1, 0, 3'b010, 32'h4000, 32'h0, 5'd2, 1, "to");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to.req%0d", i), 32'(mem_req), 32'd1);
      cyc();
    end
    chk("to.reqlo", 32'(mem_req), 32'd0);
    chk("to.exc", 32'(exc_timeout), 32'd1);
    chk("to.wbv", 32'(wb_valid), 32'd0);
    cyc();
    chk("to.exc1", 32'(exc_timeout), 32'd0);

    // Ack on 4th BUSY cycle wins.
    issue(1, 0, 3'b010, 32'h4004, 32'h0, 5'd2, 1, "ta");
    for (int i = 0; i < 3; i++) cyc();
    chk("ta.req3", 32'(mem_req), 32'd1);
    ack_now(32'hCAFE_0001);
    chk("ta.wbv", 32'(wb_valid), 32'd1);
    chk("ta.data", wb_data, 32'hCAFE_0001);
    chk("ta.exc", 32'(exc_timeout), 32'd0);

    // Reset on 2nd BUSY cycle, then late ack.
    issue(1, 0, 3'b010, 32'h5000, 32'h0, 5'd9, 1, "rb");
    cyc();
    chk("rb.req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rb.stall", 32'(stall), 32'd0);
    cyc();
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    chk("rb.reqlo", 32'(mem_req), 32'd0);
    chk("rb.addr", mem_addr, 32'h0);
    chk("rb.rd", 32'(wb_rd), 32'd0);
    chk("rb.wbd", wb_data, 32'h0);
    cyc();
    mem_ack = 1'b0;
    chk("rb.wbv", 32'(wb_valid), 32'd0);
    chk("rb.exc", {exc_misalign, exc_timeout}, 32'd0);
    chk("rb.req2", 32'(mem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
